// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command master.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_TX_NINTH,
    ST_RX_BYTE,
    ST_RX_NINTH,
    ST_STOP,
    ST_FREE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam logic SCCB_WR = 1'b0;
  localparam logic SCCB_RD = 1'b1;

  localparam int unsigned START_Q = 2;
  localparam int unsigned STOP_Q  = 4;
  localparam int unsigned FREE_Q  = 4;

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-bit timebase: one-cycle tick every QDIV enabled cycles, restartable.
module sccb_quarter_tick #(
  parameter int unsigned QDIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = $clog2(QDIV);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == W'(QDIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart)   cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sccb_cmd_master.sv
// SCCB bus master: one write or read register command per valid/ready handshake.
module sccb_cmd_master
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SCL_FREQ_HZ = 100_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned ADDR_BYTES  = 1,
  parameter bit          READ_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr,
  input  logic [7:0]              cmd_wdata,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_nack,
  output logic                    busy,
  output logic                    scl,
  output logic                    sda_oe,
  input  logic                    sda_i
);

  localparam int unsigned QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);

  if (QDIV < 2) begin : g_qdiv_chk
    $error("sccb_cmd_master: QDIV must be at least 2");
  end
  if (ADDR_BYTES < 1 || ADDR_BYTES > 2) begin : g_ab_chk
    $error("sccb_cmd_master: ADDR_BYTES must be 1 or 2");
  end

  state_t                  state_q, state_d;
  quarter_t                qtr_q, qtr_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [1:0]              bytecnt_q, bytecnt_d;
  logic                    phase2_q, phase2_d;
  logic                    nack_q, nack_d;
  logic [7:0]              rxsh_q, rxsh_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    rw_q, rw_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;

  logic       tick;
  logic       accept;
  logic [7:0] cur_byte;
  logic [2:0] bitsel;
  logic [1:0] last_byte;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_nack  = nack_q;
  assign rsp_rdata = rdata_q;
  assign accept    = cmd_valid && cmd_ready;
  assign bitsel    = 3'(4'd7 - bitcnt_q);
  assign last_byte = (rw_q == SCCB_RD) ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1);

  sccb_quarter_tick #(.QDIV(QDIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .restart (accept),
    .tick    (tick)
  );

  // Byte 0 is the device ID; the second phase of a read sends only that byte.
  always_comb begin
    cur_byte = wdata_q;
    if (phase2_q || bytecnt_q == 2'd0) begin
      cur_byte = {DEV_ADDR, phase2_q};
    end else begin
      for (int unsigned i = 0; i < ADDR_BYTES; i++) begin
        if (bytecnt_q == 2'(i + 1)) cur_byte = addr_q[8*(ADDR_BYTES-1-i) +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    phase2_d  = phase2_q;
    nack_d    = nack_q;
    rxsh_d    = rxsh_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    if (tick) qtr_d = quarter_t'(qtr_q + 2'd1);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rw_d      = cmd_rw;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          qtr_d     = Q0;
          bitcnt_d  = '0;
          bytecnt_d = '0;
          phase2_d  = 1'b0;
          nack_d    = 1'b0;
          if (cmd_rw == SCCB_RD && !READ_EN) begin
            nack_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        sda_oe = 1'b1;
        if (tick && qtr_q == quarter_t'(2'(START_Q - 1))) begin
          qtr_d   = Q0;
          state_d = ST_TX_BYTE;
        end
      end
      ST_TX_BYTE: begin
        scl    = qtr_q[1];
        sda_oe = !cur_byte[bitsel];
        if (tick && qtr_q == Q3) begin
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = '0;
            state_d  = ST_TX_NINTH;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      ST_TX_NINTH: begin
        scl = qtr_q[1];
        if (tick && qtr_q == Q2) nack_d = nack_q | sda_i;
        if (tick && qtr_q == Q3) begin
          if (phase2_q) begin
            state_d = ST_RX_BYTE;
          end else if (bytecnt_q == last_byte) begin
            state_d = ST_STOP;
          end else begin
            bytecnt_d = bytecnt_q + 2'd1;
            state_d   = ST_TX_BYTE;
          end
        end
      end
      ST_RX_BYTE: begin
        scl = qtr_q[1];
        if (tick && qtr_q == Q2) rxsh_d = {rxsh_q[6:0], sda_i};
        if (tick && qtr_q == Q3) begin
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = '0;
            state_d  = ST_RX_NINTH;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      ST_RX_NINTH: begin
        scl = qtr_q[1];
        if (tick && qtr_q == Q3) state_d = ST_STOP;
      end
      ST_STOP: begin
        scl    = qtr_q[1];
        sda_oe = (qtr_q != Q3);
        if (tick && qtr_q == quarter_t'(2'(STOP_Q - 1))) state_d = ST_FREE;
      end
      ST_FREE: begin
        if (tick && qtr_q == quarter_t'(2'(FREE_Q - 1))) begin
          if (rw_q == SCCB_RD && !phase2_q) begin
            phase2_d  = 1'b1;
            bytecnt_d = '0;
            state_d   = ST_START;
          end else begin
            if (phase2_q) rdata_d = rxsh_q;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      qtr_q     <= Q0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      phase2_q  <= 1'b0;
      nack_q    <= 1'b0;
      rxsh_q    <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      phase2_q  <= phase2_d;
      nack_q    <= nack_d;
      rxsh_q    <= rxsh_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: doc/sccb_cmd_master.md
Name:
sccb_cmd_master

Overview:
- Parametrised SCCB (OV-series camera) bus master. It succeeds the fixed 0x42, write-only, ROM-driven configurator.
- Accepts one register command per valid/ready handshake. Commands are write or read, with 8- or 16-bit register address.
- Generates its own SCL timing and drives an open-drain SDA through split enable/input pins.
- Sits between the camera init sequencer (ROM walker) and the top-level SDA tristate.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- SCL_FREQ_HZ, 100_000, SCL rate. QDIV = CLK_FREQ_HZ/(4*SCL_FREQ_HZ) is the cycles per quarter-bit. QDIV < 2 is an elaboration error.
- DEV_ADDR, 7'h21, 7-bit slave ID. Transmitted byte is {DEV_ADDR, rw}, so write = 0x42 and read = 0x43.
- ADDR_BYTES, 1, register address width in bytes; legal values are 1 or 2.
- READ_EN, 1, read support. When 0, a command with cmd_rw=1 completes immediately with rsp_nack=1 and no bus activity.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high only in IDLE.
- cmd_rw, in, 1, 0 = write, 1 = read.
- cmd_addr, in, 8*ADDR_BYTES, register address, sent MSB byte first.
- cmd_wdata, in, 8, write data; ignored for reads.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, 8, read data; valid with rsp_valid; holds its value until the next read completes.
- rsp_nack, out, 1, valid with rsp_valid. Set if any ninth bit of a master-sent byte was sampled high.
- busy, out, 1, high from command accept through the rsp_valid cycle.
- scl, out, 1, SCL, push-pull.
- sda_oe, out, 1, 1 = pull SDA low; 0 = release SDA. Top level implements sda = sda_oe ? 0 : 'z.
- sda_i, in, 1, sampled SDA line.

Behaviour:
- Reset (async, reset_n=0): state IDLE, scl=1, sda_oe=0, cmd_ready=1 after release, rsp_valid=0, rsp_nack=0, rsp_rdata=0, busy=0, divider cleared.
- Reset asserted mid-transfer: bus released immediately; no stop is generated.
- Handshake: accept when cmd_valid && cmd_ready. cmd_rw, cmd_addr and cmd_wdata are latched that cycle; cmd_ready drops the next cycle.
- Back-to-back commands: a command held valid during rsp_valid is accepted on the first IDLE cycle after it.
- Quarter tick: a pulse every QDIV cycles, restarted at accept.
- Each bit takes 4 quarters:
  - Q0: scl=0; SDA updated at the start of Q0.
  - Q1: scl=0.
  - Q2: scl=1.
  - Q3: scl=1; sda_i sampled at the start of Q3.
- Bit order is MSB first.
- START: sda_oe=1 with scl=1 for 2 quarters, then enter bit Q0.
- Ninth bit of a master-sent byte: sda_oe=0 and sda_i sampled. A high sample sets a sticky nack flag; the transfer still continues, since SCCB treats this bit as don't-care.
- Ninth bit of a read byte: the master drives NA, i.e. sda_oe=0 (SDA high).
- STOP, 4 quarters:
  - Q0: scl=0, sda_oe=1.
  - Q1: scl=0, sda_oe=1.
  - Q2: scl=1, sda_oe=1.
  - Q3: scl=1, sda_oe=0.
- BUS_FREE: 4 quarters idle with scl=1 and sda_oe=0.
- State machine: IDLE -> START -> TX_BYTE/TX_NINTH (repeated) -> STOP -> FREE, then:
  - write: FREE -> DONE.
  - read, phase 1: FREE -> START, then DEV|1 (TX_BYTE/TX_NINTH) -> RX_BYTE -> RX_NINTH -> STOP -> FREE -> DONE.
- DONE lasts one cycle: rsp_valid=1, then back to IDLE.
- Write phase: START, {DEV_ADDR,0}, address byte(s), data byte, STOP, FREE.
- Read phase 1: START, {DEV_ADDR,0}, address byte(s), STOP, FREE.
- Read phase 2: START, {DEV_ADDR,1}, data byte (RX) with NA, STOP, FREE.
- The nack flag and bit/byte counters clear at accept.
- Latency, accept to rsp_valid:
  - write: (2 + 36*(ADDR_BYTES+2) + 8)*QDIV + 1 cycles.
  - read: (2 + 36*(ADDR_BYTES+1) + 8 + 2 + 72 + 8)*QDIV + 1 cycles.
- Width rules: bit counter 0..8 (4 bits); byte counter 0..3 (2 bits); divider width $clog2(QDIV).
- No counter wraps during a transfer.

Decomposition:
- Shared package sccb_pkg:
  - state enum.
  - quarter enum Q0..Q3.
  - SCCB_WR=1'b0, SCCB_RD=1'b1.
  - constants START_Q=2, STOP_Q=4, FREE_Q=4.
- One sub-module, sccb_quarter_tick:
  - parameter QDIV.
  - inputs en and restart.
  - output tick, a one-cycle pulse.
- The existing ROM walker instantiates sccb_cmd_master and drives cmd_* from ROM contents.

Test Plan:
- Write test, with CLK_FREQ_HZ=4_000_000, SCL_FREQ_HZ=100_000 (QDIV=10), slave model ACKing:
  - stimulus: write addr 0x12, data 0x80.
  - required: SDA bytes 0x42, 0x12, 0x80; rsp_valid after 1181 cycles; rsp_nack=0.
- Read test:
  - stimulus: read addr 0x0A; slave returns 0x76.
  - required: bytes 0x42, 0x0A, STOP, then 0x43; rsp_rdata=0x76; NA bit high; rsp_valid after 1641 cycles.
- 16-bit address test, with ADDR_BYTES=2:
  - stimulus: write addr 0x3008, data 0x02.
  - required: bytes 0x42, 0x30, 0x08, 0x02; latency 1541 cycles.
- No-ACK test, with the slave absent (sda_i=1):
  - stimulus: write.
  - required: full transfer completes; rsp_nack=1.
- Back-to-back and reset tests:
  - stimulus: cmd_valid held for 3 commands.
  - required: accepted on the cycle after each rsp_valid.
  - stimulus: reset_n pulsed low mid data byte.
  - required: scl=1, sda_oe=0 immediately; next command starts with a clean START.
- READ_EN=0 test:
  - stimulus: read command.
  - required: rsp_valid 1 cycle after accept; rsp_nack=1; scl stays 1.
